// File: rtl/hc595_serializer.sv
// Parallel-to-serial transmitter for a cascaded 74HC595 chain.
// Accepts a word over valid/ready, shifts it out one bit per SRCLK with a
// shift enable, then pulses latch for one cycle to drive the chain's RCLK.
module hc595_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEVICES   = 1,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic                       SRCLK,
  input  logic                       SRCLR_n,
  input  logic [WIDTH*DEVICES-1:0]   din,
  input  logic                       din_valid,
  output logic                       din_ready,
  output logic                       ser_out,
  output logic                       shift_en,
  output logic                       latch,
  output logic                       busy
);

  localparam int unsigned N  = WIDTH * DEVICES;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ser_q, ser_d;
  logic          en_q, en_d;
  logic          latch_q, latch_d;
  logic          busy_q, busy_d;

  logic          accept;
  logic          load_bit;
  logic [N-1:0]  load_rest;
  logic          next_bit;
  logic [N-1:0]  next_rest;

  // Ready only in IDLE or LATCH, and never while reset is held.
  assign din_ready = ((state_q == S_IDLE) || (state_q == S_LATCH)) && SRCLR_n;
  assign accept    = din_valid && din_ready;

  // Bit selection by transmit order: the first bit is driven straight from
  // din on the accept edge, so the shift register holds only the remainder.
  always_comb begin
    if (LSB_FIRST != 0) begin
      load_bit  = din[0];
      load_rest = din >> 1;
      next_bit  = sr_q[0];
      next_rest = sr_q >> 1;
    end else begin
      load_bit  = din[N-1];
      load_rest = din << 1;
      next_bit  = sr_q[N-1];
      next_rest = sr_q << 1;
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ser_d   = 1'b0;
    en_d    = 1'b0;
    latch_d = 1'b0;
    case (state_q)
      S_IDLE, S_LATCH: begin
        if (accept) begin
          state_d = S_SHIFT;
          sr_d    = load_rest;
          cnt_d   = CNT_LAST;
          ser_d   = load_bit;
          en_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_LATCH;
          latch_d = 1'b1;
        end else begin
          sr_d  = next_rest;
          cnt_d = cnt_q - CW'(1);
          ser_d = next_bit;
          en_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge SRCLK or negedge SRCLR_n) begin
    if (!SRCLR_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      en_q    <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ser_q   <= ser_d;
      en_q    <= en_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
    end
  end

  assign ser_out  = ser_q;
  assign shift_en = en_q;
  assign latch    = latch_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_hc595_serializer.sv
// Bench for hc595_serializer: an 8-bit MSB-first instance and a 16-bit
// LSB-first two-device chain, each feeding a behavioural 595 chain model.
module tb_hc595_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  din_a;
  logic        va, ra, sa, ea, la, ba;
  logic [15:0] din_b;
  logic        vb, rb, sb, eb, lb, bb;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  // Downstream 595 chain models: shift on SRCLK when enabled, store on latch.
  logic [7:0]  chain_a = '0, store_a = '0;
  logic [15:0] chain_b = '0, store_b = '0;

  hc595_serializer #(.WIDTH(8), .DEVICES(1), .LSB_FIRST(0)) dut_a (
    .SRCLK(clk), .SRCLR_n(rst_n), .din(din_a), .din_valid(va), .din_ready(ra),
    .ser_out(sa), .shift_en(ea), .latch(la), .busy(ba)
  );

  hc595_serializer #(.WIDTH(8), .DEVICES(2), .LSB_FIRST(1)) dut_b (
    .SRCLK(clk), .SRCLR_n(rst_n), .din(din_b), .din_valid(vb), .din_ready(rb),
    .ser_out(sb), .shift_en(eb), .latch(lb), .busy(bb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ea) chain_a <= {chain_a[6:0], sa};
    if (la) store_a <= chain_a;
    if (eb) chain_b <= {chain_b[14:0], sb};
    if (lb) store_b <= chain_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  // Bit k on the wire: MSB-first for instance A, LSB-first for instance B.
  function automatic logic exp_bit(input bit sel, input logic [15:0] d, input int k);
    logic [15:0] t;
    t = d;
    return sel ? t[k] : t[7-k];
  endfunction

  // A left-shift chain holds the wire order reversed relative to LSB-first.
  function automatic logic [15:0] exp_store(input bit sel, input logic [15:0] d);
    return sel ? rev16(d) : {8'h00, d[7:0]};
  endfunction

  task automatic drive(input bit sel, input logic [15:0] d, input logic v);
    if (sel) begin din_b = d; vb = v; end
    else begin din_a = d[7:0]; va = v; end
  endtask

  task automatic check_idle(input bit sel, input string tag);
    chk({tag, "_ser"},   sel ? sb : sa, 0);
    chk({tag, "_en"},    sel ? eb : ea, 0);
    chk({tag, "_latch"}, sel ? lb : la, 0);
    chk({tag, "_busy"},  sel ? bb : ba, 0);
  endtask

  // Present a word and wait (bounded) for the accept edge.
  task automatic accept(input bit sel, input logic [15:0] d);
    int n;
    n = 0;
    drive(sel, d, 1'b1);
    while (!(sel ? rb : ra) && n < 40) begin tick(); n++; end
    chk("ready_wait", sel ? rb : ra, 1);
    tick();
    acc_cyc = cyc;
  endtask

  // Checks every frame bit, then stops in the latch cycle without ticking.
  // With hold set, valid stays high and din is scrambled during the frame.
  task automatic stream(input bit sel, input logic [15:0] d, input bit hold, input logic [15:0] junk);
    int n;
    n = sel ? 16 : 8;
    for (int k = 0; k < n; k++) begin
      chk("ser_bit", sel ? sb : sa, exp_bit(sel, d, k));
      chk("shift_en", sel ? eb : ea, 1);
      chk("latch_early", sel ? lb : la, 0);
      chk("busy_shift", sel ? bb : ba, 1);
      chk("ready_shift", sel ? rb : ra, 0);
      if (hold) drive(sel, junk, 1'b1);
      else drive(sel, junk, 1'b0);
      tick();
    end
    chk("latch_pulse", sel ? lb : la, 1);
    chk("latch_en", sel ? eb : ea, 0);
    chk("latch_ser", sel ? sb : sa, 0);
    chk("latch_busy", sel ? bb : ba, 1);
    chk("latch_ready", sel ? rb : ra, 1);
    chk("latch_delay", cyc - acc_cyc, n);
  endtask

  task automatic close(input bit sel, input logic [15:0] d);
    drive(sel, d, 1'b0);
    tick();
    check_idle(sel, "post");
    chk("post_ready", sel ? rb : ra, 1);
    chk("store", sel ? store_b : {8'h00, store_a}, exp_store(sel, d));
  endtask

  task automatic b2b(input bit sel, input logic [15:0] dprev, input logic [15:0] dnext);
    drive(sel, dnext, 1'b1);
    tick();
    acc_cyc = cyc;
    chk("store_b2b", sel ? store_b : {8'h00, store_a}, exp_store(sel, dprev));
  endtask

  initial begin
    logic [15:0] d, nd;
    int          t1, gap;
    bit          chain_next;

    rst_n = 1'b0;
    drive(0, 16'h0, 1'b0);
    drive(1, 16'h0, 1'b0);

    // Reset behaviour, including din_valid asserted while held in reset.
    va = 1'b1;
    tick(); tick();
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");
    chk("rst_ready_a", ra, 0);
    chk("rst_ready_b", rb, 0);
    va = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_ready_a", ra, 1);
    chk("rel_busy_a", ba, 0);
    chk("rel_ready_b", rb, 1);

    // Single frame A5.
    accept(0, 16'h00A5);
    stream(0, 16'h00A5, 1'b0, 16'h0);
    close(0, 16'h00A5);
    tick();

    // Back-to-back 3C then C3 with valid held; second accept in the latch cycle.
    accept(0, 16'h003C);
    stream(0, 16'h003C, 1'b1, 16'h00C3);
    t1 = cyc;
    b2b(0, 16'h003C, 16'h00C3);
    stream(0, 16'h00C3, 1'b0, 16'h0);
    chk("latch_spacing", cyc - t1, 9);
    close(0, 16'h00C3);

    // Input changes during the frame are ignored.
    accept(0, 16'h005A);
    stream(0, 16'h005A, 1'b1, 16'h00FF);
    close(0, 16'h005A);

    // Abort 8'hFF after three bits; next frame 8'h81 is clean.
    accept(0, 16'h00FF);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    check_idle(0, "abort");
    chk("abort_ready", ra, 0);
    tick(); tick();
    check_idle(0, "abort_hold");
    chk("abort_store", store_a, 8'h5A);
    rst_n = 1'b1;
    #1;
    chk("abort_rel_ready", ra, 1);
    accept(0, 16'h0081);
    stream(0, 16'h0081, 1'b0, 16'h0);
    close(0, 16'h0081);

    // Two-device LSB-first chain.
    accept(1, 16'h1234);
    stream(1, 16'h1234, 1'b0, 16'h0);
    close(1, 16'h1234);

    // Randomized frames, gaps and back-to-back transfers on both instances.
    for (int s = 0; s < 2; s++) begin
      chain_next = 1'b0;
      d = '0;
      for (int f = 0; f < (s == 0 ? 20 : 8); f++) begin
        nd = 16'($urandom);
        if (!chain_next) accept(s[0], nd);
        else b2b(s[0], d, nd);
        d = nd;
        stream(s[0], d, 1'($urandom_range(1)), 16'($urandom));
        chain_next = 1'($urandom_range(1));
        if (!chain_next) begin
          close(s[0], d);
          gap = $urandom_range(3);
          for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap_ready", s[0] ? rb : ra, 1);
            check_idle(s[0], "gap");
          end
        end
      end
      if (chain_next) close(s[0], d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
